// File: rtl/t2mi_pacer_pkg.sv
// t2mi_pacer_pkg
//  Shared definitions for the TS->T2-MI pacer: pacer FSM state codes and
//  the packetizer state-monitor codes the pacer watches.
package t2mi_pacer_pkg;

  typedef enum logic [1:0] {
    PACER_IDLE  = 2'd0,
    PACER_PRIME = 2'd1,
    PACER_RUN   = 2'd2,
    PACER_DRAIN = 2'd3
  } pacer_state_t;

  // Packetizer state-monitor codes
  localparam logic [3:0] T2MI_ST_INSERT_UP = 4'h3;
  localparam logic [3:0] T2MI_ST_CRC32     = 4'h7;
  localparam logic [3:0] T2MI_ST_HEADER    = 4'h0;

  localparam int USEDW_W = 13;
  localparam int STATS_W = 16;

  // RUN and DRAIN both keep the NCO and credit logic running.
  function automatic logic is_pacing(input pacer_state_t s);
    return (s == PACER_RUN) || (s == PACER_DRAIN);
  endfunction

endpackage

// File: rtl/t2mi_pacer_rate_nco.sv
// rate_nco
//  Fractional NCO: every enabled cycle adds NUM to the accumulator modulo DEN
//  and pulses TICK when the sum wraps, giving TICK rate = f_CLK*NUM/DEN.
//  Ports:
//   CLK   in   clock
//   RST   in   asynchronous active-low reset (accumulator to 0)
//   CLR   in   synchronous accumulator clear, wins over ENA
//   ENA   in   advance the accumulator this cycle
//   NUM   in   increment (NUM < DEN)
//   DEN   in   modulus (DEN != 0)
//   TICK  out  combinational wrap pulse for the current cycle
module rate_nco #(
  parameter int ACC_W = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             ENA,
  input  logic [ACC_W-1:0] NUM,
  input  logic [ACC_W-1:0] DEN,
  output logic             TICK
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;
  logic             wrap;

  // One extra bit so acc + NUM never overflows before the compare.
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, NUM};
    diff = sum - {1'b0, DEN};
    wrap = (sum >= {1'b0, DEN});
  end

  assign TICK = ENA & wrap;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc <= '0;
    end else if (CLR) begin
      acc <= '0;
    end else if (ENA) begin
      acc <= wrap ? diff[ACC_W-1:0] : sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/t2mi_pacer.sv
// t2mi_pacer
//  Run/stop and rate controller for the TS->T2-MI packetizer. A fractional
//  NCO earns byte credits; each credit is spent as one registered ENA_TS2T2MI
//  cycle when the output FIFO is not almost full. The pacer primes on input
//  FIFO fill, and a stop request only takes effect on a T2-MI packet boundary
//  (end of CRC-32 followed by the next header).
//  Ports:
//   CLK, RST          clock, asynchronous active-low reset
//   START, STOP       level-sampled run/stop requests (STOP wins)
//   CLR_STATS         synchronous clear of UNDERRUN_CNT and CREDIT_OVF
//   RATE_NUM/RATE_DEN NCO increment / modulus
//   IN_USEDW, EMPTY   input TS FIFO fill and empty flag
//   OUT_ALMOST_FULL   output T2-MI FIFO backpressure
//   STATE_MON         packetizer state monitor
//   ENA_TS2T2MI       registered packetizer clock enable
//   BUSY, PACER_STATE FSM status
//   UNDERRUN_CNT      saturating count of enabled insert_up cycles while EMPTY
//   CREDIT_OVF        sticky: a credit was dropped at saturation
module t2mi_pacer
  import t2mi_pacer_pkg::*;
#(
  parameter int ACC_W       = 24,
  parameter int CREDIT_W    = 4,
  parameter int CREDIT_MAX  = 8,
  parameter int PRIME_LEVEL = 1504
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STOP,
  input  logic               CLR_STATS,
  input  logic [ACC_W-1:0]   RATE_NUM,
  input  logic [ACC_W-1:0]   RATE_DEN,
  input  logic [USEDW_W-1:0] IN_USEDW,
  input  logic               EMPTY,
  input  logic               OUT_ALMOST_FULL,
  input  logic [3:0]         STATE_MON,
  output logic               ENA_TS2T2MI,
  output logic               BUSY,
  output logic [1:0]         PACER_STATE,
  output logic [STATS_W-1:0] UNDERRUN_CNT,
  output logic               CREDIT_OVF
);

  localparam logic [CREDIT_W-1:0] CREDIT_TOP = CREDIT_W'(CREDIT_MAX);
  localparam logic [USEDW_W-1:0]  PRIME_FILL = USEDW_W'(PRIME_LEVEL);

  pacer_state_t        state;
  logic [CREDIT_W-1:0] credit;
  logic [3:0]          state_mon_p1;
  logic [CREDIT_W:0]   credit_upd;
  logic                pacing, tick, spend, boundary, go_idle, nco_clr, underrun;

  // Credit step: tick and spend cancel; a tick at the ceiling with no spend
  // is dropped and reported in the MSB. Spend implies c != 0, so no wrap.
  function automatic logic [CREDIT_W:0] credit_step(input logic [CREDIT_W-1:0] c,
                                                    input logic tk,
                                                    input logic sp);
    logic [CREDIT_W-1:0] n;
    logic                lost;
    n    = c;
    lost = 1'b0;
    if (tk && !sp) begin
      if (c == CREDIT_TOP) lost = 1'b1;
      else                 n = c + CREDIT_W'(1);
    end else if (!tk && sp) begin
      n = c - CREDIT_W'(1);
    end
    return {lost, n};
  endfunction

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + STATS_W'(1);
  endfunction

  always_comb begin
    pacing     = is_pacing(state);
    spend      = pacing && (credit != '0) && !OUT_ALMOST_FULL;
    boundary   = (state_mon_p1 == T2MI_ST_CRC32) && (STATE_MON == T2MI_ST_HEADER);
    // A START in DRAIN cancels the drain even on a boundary cycle.
    go_idle    = (state == PACER_DRAIN) && !(START && !STOP) && boundary;
    nco_clr    = !pacing || go_idle;
    credit_upd = credit_step(credit, tick, spend);
    underrun   = ENA_TS2T2MI && (STATE_MON == T2MI_ST_INSERT_UP) && EMPTY;
  end

  rate_nco #(.ACC_W(ACC_W)) u_nco (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (nco_clr),
    .ENA  (pacing),
    .NUM  (RATE_NUM),
    .DEN  (RATE_DEN),
    .TICK (tick)
  );

  // FSM, credit counter and boundary-detect register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= PACER_IDLE;
      BUSY         <= 1'b0;
      ENA_TS2T2MI  <= 1'b0;
      credit       <= '0;
      state_mon_p1 <= T2MI_ST_HEADER;
    end else begin
      state_mon_p1 <= STATE_MON;
      credit       <= nco_clr ? '0 : credit_upd[CREDIT_W-1:0];
      case (state)
        PACER_IDLE: begin
          ENA_TS2T2MI <= 1'b0;
          if (START && !STOP) begin
            state <= PACER_PRIME;
            BUSY  <= 1'b1;
          end
        end
        PACER_PRIME: begin
          ENA_TS2T2MI <= 1'b0;
          if (STOP) begin
            state <= PACER_IDLE;
            BUSY  <= 1'b0;
          end else if (IN_USEDW >= PRIME_FILL) begin
            state <= PACER_RUN;
          end
        end
        PACER_RUN: begin
          ENA_TS2T2MI <= spend;
          if (STOP) state <= PACER_DRAIN;
        end
        PACER_DRAIN: begin
          if (START && !STOP) begin
            ENA_TS2T2MI <= spend;
            state       <= PACER_RUN;
          end else if (go_idle) begin
            // Packet just closed: stop the packetizer before the next header byte.
            ENA_TS2T2MI <= 1'b0;
            state       <= PACER_IDLE;
            BUSY        <= 1'b0;
          end else begin
            ENA_TS2T2MI <= spend;
          end
        end
        default: begin
          ENA_TS2T2MI <= 1'b0;
          state       <= PACER_IDLE;
          BUSY        <= 1'b0;
        end
      endcase
    end
  end

  // Statistics; CLR_STATS wins over a same-cycle event
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      UNDERRUN_CNT <= '0;
      CREDIT_OVF   <= 1'b0;
    end else if (CLR_STATS) begin
      UNDERRUN_CNT <= '0;
      CREDIT_OVF   <= 1'b0;
    end else begin
      if (underrun)          UNDERRUN_CNT <= sat_inc(UNDERRUN_CNT);
      if (credit_upd[CREDIT_W]) CREDIT_OVF <= 1'b1;
    end
  end

  assign PACER_STATE = state;

endmodule
